// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the fetch/data requesters, the shared data memory and the arbiter.
// The master modport is the arbiter side; slave is the requester/memory environment.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 64
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ack;
   logic [31:0]       if_rdata;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [63:0]       d_wdata;
   logic              d_ack;
   logic [63:0]       d_rdata;
   logic              bus_err;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [63:0]       mem_wdata;
   logic [63:0]       mem_rdata;
   logic              mem_ready;
   logic              stall;

   modport master (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
      output if_ack, if_rdata, d_ack, d_rdata, bus_err, mem_en, mem_we, mem_addr,
             mem_wdata, stall
   );

   modport slave (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
      input  if_ack, if_rdata, d_ack, d_rdata, bus_err, mem_en, mem_we, mem_addr,
             mem_wdata, stall
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serializes fetch and load/store accesses onto the single-port data memory with a per-access timeout.
// Define MEMARB_RR_EN for round-robin tie-breaking; otherwise data always wins ties.
module mem_port_arbiter #(
   parameter int ADDR_W  = 64,
   parameter int TIMEOUT = 15
) (
   input  logic                  clock,
   input  logic                  reset,
   mem_port_arbiter_if.master    bus
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, FETCH, DATA, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic             grant_data;
   logic [31:0]      fetch_lane;

`ifdef MEMARB_RR_EN
   logic last_data;

   // A tie goes to fetch when data won last time, so consecutive ties alternate.
   always_comb begin
      grant_data = bus.d_req & ~(bus.if_req & last_data);
   end
`else
   always_comb begin
      grant_data = bus.d_req;
   end
`endif

   always_comb begin
      fetch_lane = bus.mem_addr[2] ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
   end

   assign bus.stall = (bus.if_req & ~bus.if_ack) | (bus.d_req & ~bus.d_ack);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         wait_cnt      <= '0;
         bus.if_ack    <= 1'b0;
         bus.d_ack     <= 1'b0;
         bus.bus_err   <= 1'b0;
         bus.mem_en    <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.if_rdata  <= '0;
         bus.d_rdata   <= '0;
`ifdef MEMARB_RR_EN
         last_data     <= 1'b1;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.if_req || bus.d_req) begin
                  state         <= grant_data ? DATA : FETCH;
                  wait_cnt      <= '0;
                  bus.mem_en    <= 1'b1;
                  // mem_we doubles as the latched d_we for the rest of the access
                  bus.mem_we    <= grant_data & bus.d_we;
                  bus.mem_addr  <= grant_data ? bus.d_addr : (bus.if_addr & ~ADDR_W'(3));
                  bus.mem_wdata <= bus.d_wdata;
`ifdef MEMARB_RR_EN
                  last_data     <= grant_data;
`endif
               end
            end
            FETCH, DATA: begin
               if (bus.mem_ready || wait_cnt == CNT_MAX) begin
                  state       <= DONE;
                  bus.mem_en  <= 1'b0;
                  bus.mem_we  <= 1'b0;
                  bus.bus_err <= ~bus.mem_ready;
                  bus.if_ack  <= (state == FETCH);
                  bus.d_ack   <= (state == DATA);
                  if (state == FETCH)
                     bus.if_rdata <= bus.mem_ready ? fetch_lane : '0;
                  else
                     bus.d_rdata <= (bus.mem_ready && !bus.mem_we) ? bus.mem_rdata : '0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            DONE: begin
               state       <= IDLE;
               bus.if_ack  <= 1'b0;
               bus.d_ack   <= 1'b0;
               bus.bus_err <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed checks of mem_port_arbiter against a transaction-level model and a
// backing-store memory model; build with MEMARB_RR_EN to model round-robin ties.
module tb_mem_port_arbiter;
   localparam int ADDR_W  = 64;
   localparam int TIMEOUT = 15;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

   mem_port_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int          checks = 0;
   int          passed = 0;
   logic [63:0] ram     [128];
   logic [63:0] ref_mem [128];
   bit          last_data = 1'b1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One access from its sampling edge to the IDLE cycle after its ack.
   task automatic serve(input bit is_d, input bit other, input logic [63:0] addr,
                        input bit we, input logic [63:0] wd, input int waits);
      bit          timed;
      int          cycles;
      logic [6:0]  idx;
      logic [63:0] exp_addr;
      logic [63:0] exp_data;
      logic [63:0] word;
      timed    = waits > TIMEOUT;
      cycles   = timed ? TIMEOUT + 1 : waits + 1;
      idx      = addr[9:3];
      exp_addr = is_d ? addr : {addr[63:2], 2'b00};
      tick();
      if (!other) begin
         bus.if_addr = {$urandom, $urandom};
         bus.d_addr  = {$urandom, $urandom};
         bus.d_we    = 1'($urandom);
         bus.d_wdata = {$urandom, $urandom};
      end
      for (int k = 0; k < cycles; k++) begin
         chk("busy_ctl", {bus.mem_en, bus.mem_we, bus.if_ack, bus.d_ack, bus.stall},
             {1'b1, is_d & we, 1'b0, 1'b0, 1'b1});
         chk("mem_addr", bus.mem_addr, exp_addr);
         if (is_d && we) chk("mem_wdata", bus.mem_wdata, wd);
         bus.mem_ready = !timed && (k == waits);
         bus.mem_rdata = ram[bus.mem_addr[9:3]];
         if (bus.mem_ready && bus.mem_we) ram[bus.mem_addr[9:3]] = bus.mem_wdata;
         tick();
      end
      bus.mem_ready = 1'($urandom);
      word = ref_mem[idx];
      if (timed)      exp_data = '0;
      else if (is_d)  exp_data = we ? 64'd0 : word;
      else            exp_data = {32'd0, addr[2] ? word[63:32] : word[31:0]};
      if (!timed && is_d && we) ref_mem[idx] = wd;
      chk("ack_ctl", {bus.if_ack, bus.d_ack, bus.bus_err, bus.mem_en, bus.stall},
          {!is_d, is_d, timed, 1'b0, other});
      chk(is_d ? "d_rdata" : "if_rdata", is_d ? bus.d_rdata : {32'd0, bus.if_rdata}, exp_data);
      $display("txn %s we=%0d addr=%h waits=%0d err=%0d data=%h",
               is_d ? "data " : "fetch", is_d & we, exp_addr, waits, timed, exp_data);
      if (is_d) bus.d_req = 1'b0; else bus.if_req = 1'b0;
      tick();
      chk("idle_ctl", {bus.if_ack, bus.d_ack, bus.mem_en, bus.stall}, {3'b000, other});
   endtask

   task automatic access(input bit rq_if, input bit rq_d, input logic [63:0] ia,
                         input logic [63:0] da, input logic [63:0] wd, input bit we,
                         input int w_first, input int w_second);
      bit g_d;
      bit both;
      both = rq_if & rq_d;
`ifdef MEMARB_RR_EN
      g_d = both ? !last_data : rq_d;
`else
      g_d = rq_d;
`endif
      bus.if_req  = rq_if;
      bus.d_req   = rq_d;
      bus.if_addr = ia;
      bus.d_addr  = da;
      bus.d_we    = we;
      bus.d_wdata = wd;
      last_data   = g_d;
      serve(g_d, both, g_d ? da : ia, we, wd, w_first);
      if (both) begin
         last_data = !g_d;
         serve(!g_d, 1'b0, g_d ? ia : da, we, wd, w_second);
      end
   endtask

   initial begin
      logic [63:0] v;
      for (int i = 0; i < 128; i++) begin
         v = {$urandom, $urandom};
         ram[i] = v;
         ref_mem[i] = v;
      end
      ram[32] = 64'hAAAA_BBBB_CCCC_DDDD;
      ref_mem[32] = 64'hAAAA_BBBB_CCCC_DDDD;
      bus.if_req = 0; bus.d_req = 0; bus.d_we = 0;
      bus.if_addr = '0; bus.d_addr = '0; bus.d_wdata = '0;
      bus.mem_rdata = '0; bus.mem_ready = 0;

      repeat (3) tick();
      chk("reset_ctl", {bus.if_ack, bus.d_ack, bus.bus_err, bus.mem_en, bus.mem_we}, 0);
      chk("reset_addr", bus.mem_addr, 0);
      chk("reset_wdata", bus.mem_wdata, 0);
      chk("reset_rdata", {bus.if_rdata, bus.d_rdata[31:0]} | {32'd0, bus.d_rdata[63:32]}, 0);
      reset = 1'b0;
      tick();

      // Directed cases from the plan
      access(1, 0, 64'h104, 64'h0, 64'h0, 0, 0, 0);
      access(0, 1, 64'h0, 64'h40, 64'h1234, 1, 3, 0);
      access(0, 1, 64'h0, 64'h40, 64'h0, 0, 0, 0);
      access(1, 1, 64'h200, 64'h88, 64'h5555, 1, 1, 0);
      access(1, 1, 64'h2C4, 64'h90, 64'h0, 0, 0, 2);
      access(1, 1, 64'h308, 64'h98, 64'h77, 1, 0, 0);
      access(0, 1, 64'h0, 64'h60, 64'hDEAD, 1, 40, 0);
      access(1, 0, 64'h1F4, 64'h0, 64'h0, 0, TIMEOUT + 1, 0);
      access(0, 1, 64'h0, 64'h60, 64'h0, 0, TIMEOUT, 0);

      // Randomized traffic
      for (int n = 0; n < 40; n++) begin
         int pat;
         int sel;
         int w1;
         int w2;
         pat = $urandom_range(1, 3);
         sel = $urandom_range(0, 9);
         w1  = (sel == 0) ? TIMEOUT + 1 : (sel == 1) ? TIMEOUT : $urandom_range(0, 3);
         w2  = $urandom_range(0, 3);
         access(pat[0], pat[1], 64'($urandom_range(0, 1023)), 64'($urandom_range(0, 1023)),
                {$urandom, $urandom}, 1'($urandom), w1, w2);
      end

      // Reset in the middle of a waited store
      bus.d_req = 1; bus.d_we = 1; bus.d_addr = 64'h80; bus.d_wdata = 64'hBEEF;
      bus.mem_ready = 0;
      tick();
      tick();
      tick();
      #2;
      reset = 1'b1;
      #1;
      chk("midrst_ctl", {bus.mem_en, bus.mem_we, bus.if_ack, bus.d_ack, bus.bus_err}, 0);
      chk("midrst_addr", bus.mem_addr, 0);
      bus.d_req = 0;
      last_data = 1'b1;
      tick();
      reset = 1'b0;
      for (int c = 0; c < 20; c++) begin
         bus.mem_ready = 1'($urandom);
         tick();
         chk("post_rst_quiet", {bus.if_ack, bus.d_ack, bus.mem_en}, 0);
      end
      bus.mem_ready = 0;
      access(0, 1, 64'h0, 64'h80, 64'h0, 0, 1, 0);
      access(1, 1, 64'h10C, 64'h80, 64'hFACE, 1, 0, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer sharing the single-port 64-bit data memory between the instruction-fetch path and the load/store datapath (EN_RAM/WM traffic from the control word). It serializes requests, drives the memory handshake, and returns a stall to the control unit while any request is outstanding. A per-access timeout converts a hung memory into an error acknowledge.

## Interface
Parameters:
- ADDR_W, 64, address width of both ports and memory
- TIMEOUT, 15, max cycles waiting on mem_ready per access (≥1)

Ports (reset asynchronous, active-high; clock `clock`):
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous active-high reset
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  ADDR_W  fetch byte address (bits [1:0] ignored)
- if_ack  out  1  one-cycle fetch completion
- if_rdata  out  32  fetched instruction
- d_req  in  1  load/store request, held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  64  store data
- d_ack  out  1  one-cycle data completion
- d_rdata  out  64  load data
- bus_err  out  1  valid with an ack; 1 = access timed out
- mem_en  out  1  memory access active
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  64  memory write data
- mem_rdata  in  64  memory read data, valid when mem_ready
- mem_ready  in  1  memory completes access this cycle
- stall  out  1  freeze PC / control state

## Operation
- FSM states: IDLE, FETCH, DATA, DONE. Reset → IDLE.
- IDLE: sample requests at rising edge. Only d_req → DATA; only if_req → FETCH; both → DATA (fixed data priority; see Configuration); none → IDLE.
- On entering FETCH/DATA: latch address, d_we, d_wdata into internal registers; clear timeout counter.
- FETCH/DATA: mem_en=1, mem_addr=latched address, mem_we=latched d_we in DATA only (0 in FETCH), mem_wdata=latched wdata.
- On edge with mem_ready=1: capture read data, bus_err←0, → DONE.
- Fetch lane select: if_rdata = latched addr[2] ? mem_rdata[63:32] : mem_rdata[31:0].
- Store: d_rdata←0.
- Counter increments each cycle with mem_ready=0; when it reaches TIMEOUT → DONE with bus_err=1, read data 0.
- DONE: exactly one of if_ack/d_ack high (granted port), bus_err valid; requests ignored; → IDLE.
- stall = (if_req & ~if_ack) | (d_req & ~d_ack), combinational.
- Requester must drop req in ack cycle (or re-raise it for a new access); the arbiter does not sample requests in DONE, so a req still high in IDLE is a new access.

## Timing
- Reset values: if_ack, d_ack, bus_err, mem_en, mem_we = 0; mem_addr, mem_wdata, if_rdata, d_rdata = 0; FSM IDLE; counter 0.
- Best-case latency: req sampled edge N → FETCH/DATA cycle N+1 (mem_ready=1) → ack cycle N+2. Throughput: one access per 3 cycles minimum.
- Each wait cycle (mem_ready=0) adds one cycle; timeout ack occurs TIMEOUT+2 cycles after the sample edge.
- mem_ready outside FETCH/DATA is ignored.
- Request changes after grant have no effect (latched).
- Reset mid-access: all outputs return to reset values immediately (asynchronous), access abandoned, no ack issued.

## Configuration
- MEMARB_RR_EN defined: ties in IDLE resolved round-robin via a last-grant register (reset value = data, so the first tie goes to fetch); grant alternates on consecutive ties. Non-tied requests are unaffected.
- Undefined: fixed priority, data always wins ties; no last-grant register.

## Test plan
- Fetch only: if_addr=0x104, mem_rdata=0xAAAA_BBBB_CCCC_DDDD, mem_ready=1 → if_ack two cycles after sampling, if_rdata=0xAAAABBBB, mem_we=0 throughout.
- Store with 3 wait states: d_we=1, d_addr=0x40, d_wdata=0x1234 → mem_en/mem_we high 4 cycles with mem_addr=0x40, d_ack 5 cycles after the sampling edge, d_rdata=0, bus_err=0, stall high until the ack cycle.
- Simultaneous if_req and d_req held: without macro, DATA then FETCH; with MEMARB_RR_EN, FETCH, DATA, FETCH over repeated ties.
- Timeout: TIMEOUT=15, mem_ready stuck 0 → ack with bus_err=1 17 cycles after the sampling edge, data output 0, FSM back to IDLE.
- Reset asserted mid-DATA wait → mem_en, mem_we and acks 0 in the same cycle; after release, no ack until a new request.
